ahb_mem_arbiter: RTL and testbench
==================================

Name: ahb_mem_arbiter

Overview:
- Shares the single AHB-Lite memory port between the instruction-cache line-fill requester (I) and the data-cache fill/writeback requester (D).
- Accepts one outstanding 4-word transaction per requester and drives HADDR/HWRITE/HWDATA for the granted requester until HREADY.
- Returns registered read data and a one-cycle done pulse to that requester.
- Sits between the two caches and the bus/memory wrapper. Includes a bus-hang timeout.

Parameters:
- ADDR_W, 32, address width
- LINE_W, 128, line width (4 x 32-bit words)
- TIMEOUT, 255, max wait cycles for HREADY in a grant state; 0 disables the timeout

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- i_req  in  1  I-side request; held high with i_addr stable until i_done or i_err
- i_addr  in  ADDR_W  I-side line address (I-side is read-only)
- i_done  out  1  one-cycle pulse: i_rdata valid
- i_err  out  1  one-cycle pulse: I transaction timed out
- i_rdata  out  LINE_W  I-side read line
- d_req  in  1  D-side request; held with d_addr, d_write, d_wdata stable until d_done or d_err
- d_addr  in  ADDR_W  D-side line address
- d_write  in  1  1 = writeback, 0 = fill
- d_wdata  in  LINE_W  writeback line
- d_done  out  1  one-cycle pulse: D transaction complete; d_rdata valid for reads
- d_err  out  1  one-cycle pulse: D transaction timed out
- d_rdata  out  LINE_W  D-side read line
- HADDR  out  ADDR_W  bus address
- HWRITE  out  1  bus write strobe
- HWDATA  out  LINE_W  bus write data
- HRDATA  in  LINE_W  bus read data
- HREADY  in  1  bus transfer complete

Behaviour:
- Reset (HRESETn low, asynchronous): state=IDLE; all done/err=0; i_rdata=d_rdata=0; last_grant=I (so D wins the first tie); timeout counter=0.
- States:
  - IDLE: HADDR=0, HWRITE=0, HWDATA=0.
  - GNT_I: drive HADDR=i_addr, HWRITE=0, HWDATA=0.
  - GNT_D: drive HADDR=d_addr, HWRITE=d_write, HWDATA=d_wdata.
  - Bus outputs are combinational from state and the selected requester's inputs.
- Request masking: eff_i = i_req & ~i_done & ~i_err; eff_d = d_req & ~d_done & ~d_err. This stops re-granting a request in the cycle its completion pulse is visible.
- IDLE transitions:
  - Only eff_i -> GNT_I.
  - Only eff_d -> GNT_D.
  - Both -> grant the requester that is not last_grant (round-robin). Update last_grant on every grant.
  - Neither -> stay in IDLE.
- GNT_x, HREADY=1 in cycle t:
  - Capture HRDATA into x_rdata at edge t+1, but only for reads; writes leave x_rdata unchanged.
  - x_done=1 during cycle t+1 only.
  - state=IDLE at t+1.
- Minimum service: 1 cycle to grant, then HREADY latency, then 1 cycle done.
  - With HREADY=1 in the first grant cycle: req at t0, GNT at t1, done at t2.
  - A new grant is possible at t3 at the earliest.
- Timeout:
  - The counter clears on entry to GNT_x and increments each GNT_x cycle without HREADY.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with HREADY=0, then x_err=1 for the next cycle, state=IDLE, and rdata is unchanged.
  - HREADY=1 in the same cycle as reaching TIMEOUT counts as success, not error.
  - The counter saturates and never wraps.
- Requester dropping req while granted is a protocol violation. The arbiter stays in GNT_x and completes; the bench asserts this never happens.
- done and err are mutually exclusive and never both sides in the same cycle.
- Reset mid-grant: immediate return to IDLE; no done or err is issued for the aborted transaction.
- HREADY in IDLE is ignored.

Decomposition:
- Package ahb_arb_pkg:
  - state enum arb_state_t {IDLE, GNT_I, GNT_D}
  - requester enum req_id_t {REQ_I, REQ_D}
  - TIMEOUT_W derived from TIMEOUT via $clog2(TIMEOUT+1)
- One sub-module ahb_rr_pick: combinational two-way round-robin picker (eff_i, eff_d, last_grant -> grant_valid, grant_id). Timeout counter and FSM stay in the top.

Test Plan:
- Single I read: i_req=1, i_addr=0x100, HREADY=1 one cycle after grant, HRDATA=0xA..A -> HADDR=0x100 with HWRITE=0 for exactly 1 cycle; i_done one cycle later; i_rdata=0xA..A; back to IDLE.
- D writeback: d_write=1, d_addr=0x2000, d_wdata=0x1234..., HREADY delayed 3 cycles -> HWRITE=1 and HWDATA stable for 4 cycles; d_done pulse; d_rdata unchanged.
- Simultaneous requests from reset: i_req and d_req both held -> D granted first (last_grant=I at reset), then I; repeated back-to-back pairs alternate D,I,D,I; no starvation.
- Timeout: TIMEOUT=4, d_req with HREADY stuck 0 -> d_err asserted exactly 5 cycles after grant entry; state IDLE; d_done never set. With HREADY=1 in the 4th wait cycle -> d_done, no err.
- Reset mid-transaction: HRESETn low during GNT_I -> all outputs at reset values asynchronously; no i_done after release; i_req held -> regranted normally.
- No double grant: requester drops req in the same cycle as its done pulse -> no second bus access to that address, checked by an assertion.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB-Lite memory arbiter.
// Arbiter states, requester ids and timeout counter sizing.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    // Counter width able to hold the timeout value; never narrower than 1.
    function automatic int tmo_width(input int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

    localparam int TIMEOUT_DEF = 255;
    localparam int TIMEOUT_W   = tmo_width(TIMEOUT_DEF);

endpackage

// File: rtl/ahb_rr_pick.sv
// Two-way round-robin picker between I-cache and D-cache requests.
// On a tie the requester that was not granted last wins.
module ahb_rr_pick
    import ahb_arb_pkg::*;
(
    input  logic    i_vld_i,
    input  logic    d_vld_i,
    input  req_id_t last_i,
    output logic    valid_o,
    output req_id_t id_o
);

    // Select the winner from the two effective requests.
    always_comb begin
        valid_o = i_vld_i | d_vld_i;
        id_o    = REQ_I;
        unique case ({i_vld_i, d_vld_i})
            2'b11:   id_o = (last_i == REQ_I) ? REQ_D : REQ_I;
            2'b01:   id_o = REQ_D;
            default: id_o = REQ_I;
        endcase
    end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Arbiter sharing one AHB-Lite memory port between I and D caches.
// One 4-word transaction per grant, registered done/err, bus-hang timeout.
module ahb_mem_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
)(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic              i_err,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [LINE_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [LINE_W-1:0] HWDATA,
    input  logic [LINE_W-1:0] HRDATA,
    input  logic              HREADY
);

    localparam int CNT_W = tmo_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t        state_q, state_d;
    req_id_t           last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              i_done_q, i_done_d;
    logic              i_err_q, i_err_d;
    logic              d_done_q, d_done_d;
    logic              d_err_q, d_err_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic    eff_i;
    logic    eff_d;
    logic    pick_vld;
    req_id_t pick_id;
    logic    tmo_hit;

    // A request whose completion pulse is visible must not be re-granted.
    assign eff_i = i_req & ~i_done_q & ~i_err_q;
    assign eff_d = d_req & ~d_done_q & ~d_err_q;

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_TMO);

    ahb_rr_pick u_pick (
        .i_vld_i (eff_i),
        .d_vld_i (eff_d),
        .last_i  (last_q),
        .valid_o (pick_vld),
        .id_o    (pick_id)
    );

    assign i_done  = i_done_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_done  = d_done_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

    // Next-state, bus drive, completion pulses and timeout counting.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        i_done_d  = 1'b0;
        i_err_d   = 1'b0;
        d_done_d  = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HWDATA    = '0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_vld) begin
                    last_d  = pick_id;
                    state_d = (pick_id == REQ_D) ? GNT_D : GNT_I;
                end
            end
            GNT_I: begin
                HADDR = i_addr;
                if (HREADY) begin
                    state_d   = IDLE;
                    i_done_d  = 1'b1;
                    i_rdata_d = HRDATA;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    i_err_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GNT_D: begin
                HADDR  = d_addr;
                HWRITE = d_write;
                HWDATA = d_wdata;
                if (HREADY) begin
                    state_d  = IDLE;
                    d_done_d = 1'b1;
                    if (!d_write) begin
                        d_rdata_d = HRDATA;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    d_err_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant history, counter and registered responses.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            last_q    <= REQ_I;
            cnt_q     <= '0;
            i_done_q  <= 1'b0;
            i_err_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            i_done_q  <= i_done_d;
            i_err_q   <= i_err_d;
            d_done_q  <= d_done_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Self-checking bench for ahb_mem_arbiter.
// Bus slave with planned latencies, grant-order model and response scoreboard.
module tb_ahb_mem_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int TMO = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic          i_err;
    logic [LW-1:0] i_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic          d_done;
    logic          d_err;
    logic [LW-1:0] d_rdata;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [LW-1:0] HWDATA;
    logic [LW-1:0] HRDATA;
    logic          HREADY;

    ahb_mem_arbiter #(
        .ADDR_W  (AW),
        .LINE_W  (LW),
        .TIMEOUT (TMO)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_err   (i_err),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_write (d_write),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_err   (d_err),
        .d_rdata (d_rdata),
        .HADDR   (HADDR),
        .HWRITE  (HWRITE),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit            is_d;
        bit            err;
        bit            wr;
        logic [LW-1:0] data;
    } exp_t;

    int n_checks = 0;
    int n_errs   = 0;

    exp_t sbq[$];
    bit   gnt_log[$];

    int i_issued = 0, i_granted = 0, d_issued = 0, d_granted = 0;
    int i_cpl = 0, d_cpl = 0, i_errs = 0, d_errs = 0;
    int last_len = 0;

    int            force_lat = -1;
    bit            force_data_en = 0;
    logic [LW-1:0] force_data = '0;

    bit            act, act_p, busy, resp_due, ri, rd;
    bit            elig_i_p, elig_d_p, last_d, cur_d;
    int            k, lat;
    logic [LW-1:0] cur_data;
    logic [LW-1:0] mi_rdata, md_rdata;
    exp_t          e;

    task automatic chk(input string name, input logic [LW-1:0] got,
                       input logic [LW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [LW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rnd_i_addr();
        return 32'h1000_0000 | ($urandom & 32'h0FFF_FFF0);
    endfunction

    function automatic logic [AW-1:0] rnd_d_addr();
        return 32'h2000_0000 | ($urandom & 32'h0FFF_FFF0);
    endfunction

    // Monitor: bus slave, grant-order model and response scoreboard.
    initial begin : monitor
        HREADY = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                sbq.delete();
                act_p    = 0;
                busy     = 0;
                resp_due = 0;
                elig_i_p = 0;
                elig_d_p = 0;
                last_d   = 0;
                mi_rdata = '0;
                md_rdata = '0;
                HREADY   = 1'b0;
            end else begin
                act = (HADDR != '0);
                ri  = 0;
                rd  = 0;
                if (resp_due) begin
                    e = sbq.pop_front();
                    resp_due = 0;
                    chk("i_done", i_done, !e.is_d && !e.err);
                    chk("i_err", i_err, !e.is_d && e.err);
                    chk("d_done", d_done, e.is_d && !e.err);
                    chk("d_err", d_err, e.is_d && e.err);
                    if (!e.err && !e.is_d) mi_rdata = e.data;
                    if (!e.err && e.is_d && !e.wr) md_rdata = e.data;
                    chk("i_rdata", i_rdata, mi_rdata);
                    chk("d_rdata", d_rdata, md_rdata);
                    chk("idle_after_end", act, 0);
                    if (e.is_d) begin
                        d_cpl++;
                        rd = 1;
                        if (e.err) d_errs++;
                    end else begin
                        i_cpl++;
                        ri = 1;
                        if (e.err) i_errs++;
                    end
                end else begin
                    chk("no_stray_pulse", {i_done, i_err, d_done, d_err}, 0);
                end

                if (busy && !act) begin
                    chk("bus_held", act, 1);
                    busy = 0;
                    sbq.delete();
                end else if (busy) begin
                    k++;
                end else if (!act_p) begin
                    chk("grant_on_pending", act, elig_i_p | elig_d_p);
                    if (act && (elig_i_p || elig_d_p)) begin
                        cur_d = (elig_i_p && elig_d_p) ? !last_d : elig_d_p;
                        last_d = cur_d;
                        gnt_log.push_back(cur_d);
                        if (cur_d) begin
                            chk("d_fresh_req", d_issued > d_granted, 1);
                            d_granted++;
                        end else begin
                            chk("i_fresh_req", i_issued > i_granted, 1);
                            i_granted++;
                        end
                        lat = (force_lat >= 0) ? force_lat
                                               : int'($urandom_range(0, 6));
                        cur_data = force_data_en ? force_data : rnd128();
                        e.is_d = cur_d;
                        e.err  = (lat > TMO);
                        e.wr   = cur_d && d_write;
                        e.data = cur_data;
                        sbq.push_back(e);
                        busy = 1;
                        k    = 0;
                    end
                end

                if (busy) begin
                    chk("haddr", HADDR, cur_d ? d_addr : i_addr);
                    chk("hwrite", HWRITE, cur_d ? d_write : 1'b0);
                    chk("hwdata", HWDATA, cur_d ? d_wdata : '0);
                    chk("req_held", cur_d ? d_req : i_req, 1);
                    HREADY = 1'b0;
                    HRDATA = rnd128();
                    if (k == lat) begin
                        HREADY   = 1'b1;
                        HRDATA   = cur_data;
                        busy     = 0;
                        resp_due = 1;
                        last_len = k + 1;
                    end else if (k == TMO && lat > TMO) begin
                        busy     = 0;
                        resp_due = 1;
                        last_len = k + 1;
                    end
                end else begin
                    if (!act) begin
                        chk("idle_hwrite", HWRITE, 0);
                        chk("idle_hwdata", HWDATA, 0);
                    end
                    HREADY = 1'($urandom_range(0, 1));
                    HRDATA = rnd128();
                end

                elig_i_p = i_req && !ri;
                elig_d_p = d_req && !rd;
                act_p    = act;
            end
        end
    end

    task automatic i_txn(input logic [AW-1:0] a, input bit early);
        int base;
        bit ok;
        base = i_cpl;
        ok   = 0;
        @(posedge HCLK);
        #1;
        i_addr = a;
        i_req  = 1'b1;
        i_issued++;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (early) begin
                @(negedge HCLK);
                #1;
            end else begin
                @(posedge HCLK);
            end
            if (i_cpl != base) ok = 1;
        end
        chk("i_txn_complete", ok, 1);
        if (!early) #1;
        i_req = 1'b0;
    endtask

    task automatic d_txn(input logic [AW-1:0] a, input bit wr,
                         input logic [LW-1:0] wd, input bit early);
        int base;
        bit ok;
        base = d_cpl;
        ok   = 0;
        @(posedge HCLK);
        #1;
        d_addr  = a;
        d_write = wr;
        d_wdata = wd;
        d_req   = 1'b1;
        d_issued++;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (early) begin
                @(negedge HCLK);
                #1;
            end else begin
                @(posedge HCLK);
            end
            if (d_cpl != base) ok = 1;
        end
        chk("d_txn_complete", ok, 1);
        if (!early) #1;
        d_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        n_errs++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

    initial begin : main
        int  g0, e0, base;
        bit  seen;
        i_req   = 0;
        i_addr  = '0;
        d_req   = 0;
        d_addr  = '0;
        d_write = 0;
        d_wdata = '0;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_pulses", {i_done, i_err, d_done, d_err}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);

        // Simultaneous requests straight after reset: D first, then I.
        fork
            i_txn(32'h1000_0040, 0);
            d_txn(32'h2000_0080, 0, rnd128(), 0);
        join
        chk("tie_gnt_count", gnt_log.size(), 2);
        chk("tie_first_d", gnt_log[0], 1);
        chk("tie_second_i", gnt_log[1], 0);

        // Single I read, ready in the first grant cycle.
        force_lat     = 0;
        force_data_en = 1;
        force_data    = {4{32'hAAAA_AAAA}};
        i_txn(32'h0000_0100, 0);
        force_lat     = -1;
        force_data_en = 0;
        chk("t1_i_rdata", i_rdata, {4{32'hAAAA_AAAA}});
        chk("t1_len", last_len, 1);

        // D writeback with three wait cycles.
        force_lat = 3;
        d_txn(32'h0000_2000, 1, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 0);
        force_lat = -1;
        chk("t2_len", last_len, 4);
        chk("t2_d_rdata_kept", d_rdata, md_rdata);

        // Timeout: HREADY never comes.
        e0 = d_errs;
        force_lat = 5;
        d_txn(32'h2000_0100, 0, '0, 0);
        chk("t3_err", d_errs, e0 + 1);
        chk("t3_len", last_len, TMO + 1);
        // HREADY in the very cycle the counter reaches the limit.
        force_lat = TMO;
        d_txn(32'h2000_0140, 0, '0, 0);
        force_lat = -1;
        chk("t3_edge_no_err", d_errs, e0 + 1);
        chk("t3_edge_len", last_len, TMO + 1);

        // Requester drops in its done cycle: no second access.
        g0 = gnt_log.size();
        i_txn(32'h1000_0200, 1);
        repeat (5) @(posedge HCLK);
        chk("no_double_grant", gnt_log.size(), g0 + 1);

        // Reset in the middle of an I grant.
        force_lat = 20;
        @(posedge HCLK);
        #1;
        i_addr = 32'h1000_0300;
        i_req  = 1'b1;
        i_issued++;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge HCLK);
            #1;
            if (HADDR == 32'h1000_0300) seen = 1;
        end
        chk("rst_mid_granted", seen, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_haddr", HADDR, 0);
        chk("rst_mid_pulses", {i_done, i_err, d_done, d_err}, 0);
        chk("rst_mid_i_rdata", i_rdata, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        repeat (2) @(posedge HCLK);
        #1;
        force_lat = 1;
        HRESETn   = 1'b1;
        i_issued++;
        base = i_cpl;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge HCLK);
            if (i_cpl != base) seen = 1;
        end
        chk("rst_mid_regrant", seen, 1);
        #1;
        i_req     = 1'b0;
        force_lat = -1;

        // Random traffic from both requesters.
        fork
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge HCLK);
                i_txn(rnd_i_addr(), 1'($urandom_range(0, 1)));
            end
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge HCLK);
                d_txn(rnd_d_addr(), 1'($urandom_range(0, 1)), rnd128(),
                      1'($urandom_range(0, 1)));
            end
        join
        repeat (3) @(posedge HCLK);
        chk("all_i_granted", i_granted, i_issued);
        chk("all_d_granted", d_granted, d_issued);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
